// File: rtl/alm_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alm_cfg_pkg
//  Description : Shared types, chain-length constants and helpers for the
//                ALM configuration loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package alm_cfg_pkg;

    localparam int ALM_CHAIN_BASE   = 86;
    localparam int ALM_CHAIN_XOR6   = 87;
    localparam int ALM_CHAIN_MAJADD = 88;
    localparam int LUT_MASK_BITS    = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_VERIFY    = 3'd3,
        ST_DONE      = 3'd4
    } alm_cfg_state_e;

    function automatic int words_needed(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alm_cfg_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : alm_cfg_serializer
//  Description : Word-wide shift register with a bit down-counter; emits the
//                loaded word LSB first, one bit per shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module alm_cfg_serializer #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              i_shift,
    output logic              o_bit,
    output logic              o_empty,
    output logic              o_last
);

    logic [WORD_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_cnt   <= i_count;
        end else if (i_shift && (r_cnt != '0)) begin
            r_shreg <= {1'b0, r_shreg[WORD_W-1:1]};
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    assign o_bit   = r_shreg[0];
    assign o_empty = (r_cnt == '0);
    // Counter empties on the shift that is presented this cycle
    assign o_last  = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/alm_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : alm_config_loader
//  Description : Loads one ALM serial config chain from a valid/ready word
//                source and optionally verifies it by circular readback.
//  Revision    : 1.0 - initial release
// ============================================================================
module alm_config_loader
    import alm_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 86,
    parameter int WORD_W    = 16,
    parameter int VERIFY_EN = 1
) (
    input  logic              clk,
    input  logic              clear_sync,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              config_en,
    output logic              config_in,
    input  logic              config_out,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int SER_W = $clog2(WORD_W + 1);

    alm_cfg_state_e       r_state;
    alm_cfg_state_e       w_state_nxt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CHAIN_LEN-1:0] r_shadow;
    logic                 r_error;

    logic             w_ser_bit;
    logic             w_ser_empty;
    logic             w_ser_last;
    logic             w_accept;
    logic             w_bit_last;
    logic [SER_W-1:0] w_load_cnt;

    assign w_accept   = word_ready & word_valid;
    assign w_bit_last = (r_bit_cnt == CNT_W'(1));
    // Final word carries only the remaining bits; its upper bits are never shifted
    assign w_load_cnt = (int'(r_bit_cnt) >= WORD_W) ? SER_W'(WORD_W) : SER_W'(r_bit_cnt);

    alm_cfg_serializer #(
        .WORD_W (WORD_W),
        .CNT_W  (SER_W)
    ) u_serializer (
        .clk     (clk),
        .rst     (clear_sync),
        .i_load  (w_accept),
        .i_data  (word_data),
        .i_count (w_load_cnt),
        .i_shift (r_state == ST_SHIFT),
        .o_bit   (w_ser_bit),
        .o_empty (w_ser_empty),
        .o_last  (w_ser_last)
    );

    always_ff @(posedge clk) begin
        if (clear_sync) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        word_ready  = 1'b0;
        config_en   = 1'b0;
        config_in   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_WAIT_WORD;
                end
            end
            ST_WAIT_WORD: begin
                word_ready = w_ser_empty;
                if (word_valid && w_ser_empty) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                config_en = 1'b1;
                config_in = w_ser_bit;
                if (w_ser_last) begin
                    if (w_bit_last) begin
                        w_state_nxt = (VERIFY_EN != 0) ? ST_VERIFY : ST_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT_WORD;
                    end
                end
            end
            ST_VERIFY: begin
                // Loop the tail back to the head so the chain rotates to its loaded state
                config_en = 1'b1;
                config_in = config_out;
                if (w_bit_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear_sync) begin
            r_bit_cnt <= '0;
            r_shadow  <= '0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bit_cnt <= CNT_W'(CHAIN_LEN);
                        r_error   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_shadow <= {w_ser_bit, r_shadow[CHAIN_LEN-1:1]};
                    // Reload on the last load bit so the counter times the readback pass
                    if (w_ser_last && w_bit_last) begin
                        r_bit_cnt <= CNT_W'(CHAIN_LEN);
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    end
                end
                ST_VERIFY: begin
                    r_shadow  <= {r_shadow[0], r_shadow[CHAIN_LEN-1:1]};
                    r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    if (config_out != r_shadow[0]) begin
                        r_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_alm_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alm_config_loader
//  Description : Self-checking bench for alm_config_loader with an 86-bit
//                behavioural chain model and a serial-bit scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alm_config_loader;
    import alm_cfg_pkg::*;

    localparam int CL = ALM_CHAIN_BASE;
    localparam int WW = LUT_MASK_BITS;
    localparam int NW = words_needed(CL, WW);

    logic          clk = 1'b0;
    logic          clear_sync;
    logic          start;
    logic          word_valid;
    logic [WW-1:0] word_data;
    logic          word_ready;
    logic          config_en;
    logic          config_in;
    logic          config_out;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alm_config_loader #(
        .CHAIN_LEN (CL),
        .WORD_W    (WW),
        .VERIFY_EN (1)
    ) dut (
        .clk        (clk),
        .clear_sync (clear_sync),
        .start      (start),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Behavioural ALM chain: head at the top bit, tail at bit 0
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] chain_nx;
    logic          fault = 1'b0;

    always_comb begin
        chain_nx = {config_in, chain[CL-1:1]};
        if (fault) chain_nx[40] = 1'b0;
    end

    always @(posedge clk) begin
        if (config_en) chain <= chain_nx;
    end

    assign config_out = chain[0];

    typedef struct {
        logic [WW-1:0] word;
        logic [WW-1:0] last;
        int            gap;
        bit            fault;
        bit            exp_err;
        int            start_at;
    } vec_t;

    vec_t vecs[6];
    logic q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CL-1:0] exp_chain_f(input logic [WW-1:0] w, input logic [WW-1:0] last);
        logic [CL-1:0] r;
        logic [WW-1:0] cur;
        r = '0;
        for (int i = 0; i < CL; i++) begin
            cur  = ((i / WW) == NW - 1) ? last : w;
            r[i] = cur[i % WW];
        end
        return r;
    endfunction

    // Runs one load from a negedge; abort_at > 0 asserts clear_sync in that SHIFT cycle
    task automatic run_load(input vec_t v, input int abort_at);
        logic [CL-1:0] exp_chain;
        int  cyc      = 0;
        int  shifted  = 0;
        int  words    = 0;
        int  gap_left = 0;
        int  n;
        int  exp_done;
        bit  prev_en  = 1'b0;
        bit  seen     = 1'b0;
        logic b;

        exp_chain = exp_chain_f(v.word, v.last);
        exp_done  = 1 + NW + (NW - 1) * v.gap + 2 * CL;
        fault     = v.fault;
        q.delete();
        start      = 1'b1;
        word_valid = 1'b0;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (prev_en) begin
                shifted++;
                if (shifted == CL && !v.fault) check("chain_after_load", chain, exp_chain);
            end
            prev_en = config_en;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (abort_at > 0 && config_en && shifted == abort_at - 1) begin
                clear_sync = 1'b1;
                @(negedge clk);
                clear_sync = 1'b0;
                check("abort_busy", busy, 1'b0);
                check("abort_config_en", config_en, 1'b0);
                check("abort_word_ready", word_ready, 1'b0);
                check("abort_error", error, 1'b0);
                return;
            end
            check("ready_en_overlap", word_ready & config_en, 1'b0);
            if (config_en) begin
                if (shifted < CL) begin
                    if (q.size() == 0) begin
                        check("stream_underflow", 1'b1, 1'b0);
                    end else begin
                        b = q.pop_front();
                        check("config_in_bit", config_in, b);
                    end
                end else begin
                    check("verify_loopback", config_in, config_out);
                end
            end
            if (v.start_at >= 0 && config_en && shifted == v.start_at) start = 1'b1;
            if (word_ready && gap_left > 0) begin
                word_valid = 1'b0;
                gap_left--;
            end else begin
                word_valid = 1'b1;
                word_data  = word_ready ? ((words == NW - 1) ? v.last : v.word) : WW'($urandom);
            end
            if (word_ready && word_valid && words < NW) begin
                n = (CL - words * WW < WW) ? CL - words * WW : WW;
                for (int j = 0; j < n; j++) q.push_back(word_data[j]);
                words++;
                gap_left = v.gap;
            end
        end
        word_valid = 1'b0;
        check("done_seen", seen, 1'b1);
        if (seen) begin
            check("done_cycle", cyc, exp_done);
            check("en_cycles", shifted, 2 * CL);
            check("error_at_done", error, v.exp_err);
            check("stream_drained", q.size(), 0);
            if (!v.fault) check("chain_after_verify", chain, exp_chain);
            @(negedge clk);
            check("done_one_cycle", {done, busy}, 2'b00);
            check("error_hold", error, v.exp_err);
        end
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3, 0, 1'b0, 1'b0, -1};
        vecs[1] = '{16'hA5C3, 16'hA5C3, 3, 1'b0, 1'b0, -1};
        vecs[2] = '{16'h0000, 16'hFFFF, 0, 1'b0, 1'b0, -1};
        vecs[3] = '{16'h3C96, 16'h1234, 1, 1'b0, 1'b0, 10};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 0, 1'b1, 1'b1, -1};
        vecs[5] = '{16'hA5C3, 16'hA5C3, 2, 1'b0, 1'b0, 120};

        clear_sync = 1'b1;
        start      = 1'b0;
        word_valid = 1'b1;
        word_data  = 16'hBEEF;
        repeat (3) @(negedge clk);
        clear_sync = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_word_ready", word_ready, 1'b0);
        check("rst_config_en", config_en, 1'b0);
        check("rst_config_in", config_in, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i], 0);
            if (i == 4) begin
                repeat (4) begin
                    @(negedge clk);
                    check("error_sticky", error, 1'b1);
                end
            end
        end

        run_load(vecs[0], 30);
        @(negedge clk);
        run_load(vecs[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
